// File: rtl/input_conditioner.sv
// Board input conditioner: 2-FF sync, tick-sampled debounce, registered rise/fall/toggle pulses.
// Latency 2 + STABLE_TICKS*TICK_DIV clk worst case; free-running, no backpressure.
module input_conditioner #(
  parameter int N_CH         = 9,
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int STABLE_TICKS = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] clean,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] toggle,
  output logic            armed,
  output logic            tick
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W    = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [N_CH-1:0]  s1;
  logic [N_CH-1:0]  s2;
  logic [PRE_W-1:0] presc;
  logic [CNT_W-1:0] settle_cnt;
  logic             armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (presc == PRE_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  assign tick = (presc == PRE_LAST);

  // Settle window: armed goes high on the STABLE_TICKS-th tick after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      armed_q    <= 1'b0;
    end else if (tick && !armed_q) begin
      if (settle_cnt == CNT_LAST) begin
        armed_q <= 1'b1;
      end else begin
        settle_cnt <= settle_cnt + CNT_W'(1);
      end
    end
  end

  assign armed = armed_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             clean_q;
    logic             rise_q;
    logic             fall_q;
    logic             toggle_q;

    // Before arming, clean follows the sampled level silently so held buttons never pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt      <= '0;
        clean_q  <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        toggle_q <= 1'b0;
      end else begin
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        toggle_q <= 1'b0;
        if (tick) begin
          if (!armed_q) begin
            clean_q <= s2[i];
            cnt     <= '0;
          end else if (s2[i] == clean_q) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            clean_q  <= s2[i];
            cnt      <= '0;
            rise_q   <= s2[i];
            fall_q   <= ~s2[i];
            toggle_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
    end

    assign clean[i]  = clean_q;
    assign rise[i]   = rise_q;
    assign fall[i]   = fall_q;
    assign toggle[i] = toggle_q;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with TICK_DIV=10, STABLE_TICKS=3.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] raw_in;
  logic [8:0] clean;
  logic [8:0] rise;
  logic [8:0] fall;
  logic [8:0] toggle;
  logic       armed;
  logic       tick;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  input_conditioner #(
    .N_CH(9),
    .CLK_HZ(1000),
    .TICK_HZ(100),
    .STABLE_TICKS(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .raw_in(raw_in),
    .clean(clean),
    .rise(rise),
    .fall(fall),
    .toggle(toggle),
    .armed(armed),
    .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [8:0] seen;
    rst_n  = 1'b0;
    raw_in = 9'h001;
    repeat (3) step();
    chk_cnt++; if (clean !== 9'h000) $display("FAIL reset_clean: got %h want 000", clean); else pass_cnt++;
    chk_cnt++; if (toggle !== 9'h000) $display("FAIL reset_toggle: got %h want 000", toggle); else pass_cnt++;
    chk_cnt++; if (armed !== 1'b0) $display("FAIL reset_armed: got %b want 0", armed); else pass_cnt++;
    chk_cnt++; if (tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", tick); else pass_cnt++;
    rst_n = 1'b1;
    seen  = '0;
    for (int cyc = 1; cyc <= 32; cyc++) begin
      step();
      seen |= rise | fall;
      if (cyc == 9) begin
        chk_cnt++; if (tick !== 1'b1) $display("FAIL tick_first: got %b want 1 at cycle 9", tick); else pass_cnt++;
      end
      if (cyc == 10) begin
        chk_cnt++; if (tick !== 1'b0) $display("FAIL tick_width: got %b want 0 at cycle 10", tick); else pass_cnt++;
      end
      if (cyc == 29) begin
        chk_cnt++; if (armed !== 1'b0) $display("FAIL armed_early: got %b want 0 at cycle 29", armed); else pass_cnt++;
      end
      if (cyc == 30) begin
        chk_cnt++; if (armed !== 1'b1) $display("FAIL armed_at_30: got %b want 1", armed); else pass_cnt++;
        chk_cnt++; if (clean !== 9'h001) $display("FAIL settle_clean: got %h want 001", clean); else pass_cnt++;
      end
    end
    chk_cnt++; if (seen !== 9'h000) $display("FAIL settle_pulses: got %h want 000", seen); else pass_cnt++;
  endtask

  task automatic test_rise();
    int lat;
    raw_in[2] = 1'b1;
    lat = 0;
    while (clean[2] !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    chk_cnt++; if (lat < 22 || lat > 33) $display("FAIL rise_latency: got %0d clk want 22..33", lat); else pass_cnt++;
    chk_cnt++; if (rise !== 9'h004) $display("FAIL rise_pulse: got %h want 004", rise); else pass_cnt++;
    chk_cnt++; if (toggle !== 9'h004) $display("FAIL rise_toggle: got %h want 004", toggle); else pass_cnt++;
    chk_cnt++; if (fall !== 9'h000) $display("FAIL rise_nofall: got %h want 000", fall); else pass_cnt++;
    step();
    chk_cnt++; if (rise !== 9'h000) $display("FAIL rise_one_cycle: got %h want 000", rise); else pass_cnt++;
    chk_cnt++; if (clean !== 9'h005) $display("FAIL rise_clean: got %h want 005", clean); else pass_cnt++;
  endtask

  task automatic test_glitch();
    logic [8:0] seen;
    seen = '0;
    raw_in[3] = 1'b1;
    repeat (15) begin
      step();
      seen |= toggle;
    end
    raw_in[3] = 1'b0;
    repeat (45) begin
      step();
      seen |= toggle;
    end
    chk_cnt++; if (seen !== 9'h000) $display("FAIL glitch_pulses: got %h want 000", seen); else pass_cnt++;
    chk_cnt++; if (clean !== 9'h005) $display("FAIL glitch_clean: got %h want 005", clean); else pass_cnt++;
  endtask

  task automatic test_bounce();
    logic [8:0] seen;
    seen = '0;
    for (int k = 0; k < 17; k++) begin
      raw_in[5] = ~raw_in[5];
      repeat (12) begin
        step();
        seen |= toggle;
      end
    end
    raw_in[5] = 1'b0;
    repeat (40) begin
      step();
      seen |= toggle;
    end
    chk_cnt++; if (seen !== 9'h000) $display("FAIL bounce_pulses: got %h want 000", seen); else pass_cnt++;
    chk_cnt++; if (clean !== 9'h005) $display("FAIL bounce_clean: got %h want 005", clean); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n;
    raw_in[0] = 1'b0;
    n = 0;
    while (fall === 9'h000 && n < 40) begin
      step();
      n++;
    end
    chk_cnt++; if (fall !== 9'h001) $display("FAIL fall_pulse: got %h want 001", fall); else pass_cnt++;
    chk_cnt++; if (clean !== 9'h004) $display("FAIL fall_clean: got %h want 004", clean); else pass_cnt++;
    raw_in[0] = 1'b1;
    raw_in[8] = 1'b1;
    n = 0;
    while (rise === 9'h000 && n < 40) begin
      step();
      n++;
    end
    chk_cnt++; if (rise !== 9'h101) $display("FAIL simul_rise: got %h want 101", rise); else pass_cnt++;
    chk_cnt++; if (toggle !== 9'h101) $display("FAIL simul_toggle: got %h want 101", toggle); else pass_cnt++;
    chk_cnt++; if (clean !== 9'h105) $display("FAIL simul_clean: got %h want 105", clean); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    logic [8:0] seen;
    n = 0;
    while (tick !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk_cnt++; if (tick !== 1'b1) $display("FAIL tick_sync: got %b want 1", tick); else pass_cnt++;
    raw_in[4] = 1'b1;
    seen = '0;
    repeat (25) begin
      step();
      seen |= toggle;
    end
    chk_cnt++; if (seen !== 9'h000 || clean[4] !== 1'b0) $display("FAIL pending_state: pulses %h clean4 %b want 000/0", seen, clean[4]); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (clean !== 9'h000 || armed !== 1'b0) $display("FAIL async_reset: clean %h armed %b want 000/0", clean, armed); else pass_cnt++;
    repeat (3) step();
    chk_cnt++; if (toggle !== 9'h000 || tick !== 1'b0) $display("FAIL in_reset: toggle %h tick %b want 000/0", toggle, tick); else pass_cnt++;
    rst_n = 1'b1;
    seen = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step();
      seen |= toggle;
      if (cyc == 29) begin
        chk_cnt++; if (armed !== 1'b0) $display("FAIL rearm_early: got %b want 0", armed); else pass_cnt++;
      end
      if (cyc == 30) begin
        chk_cnt++; if (armed !== 1'b1) $display("FAIL rearm_at_30: got %b want 1", armed); else pass_cnt++;
      end
    end
    chk_cnt++; if (seen !== 9'h000) $display("FAIL post_reset_pulses: got %h want 000", seen); else pass_cnt++;
    chk_cnt++; if (clean !== 9'h115) $display("FAIL post_reset_clean: got %h want 115", clean); else pass_cnt++;
  endtask

  initial begin
    rst_n  = 1'b0;
    raw_in = '0;
    test_reset();
    test_rise();
    test_glitch();
    test_bounce();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Upstream stage for the whack-a-mole game core. Conditions the raw board inputs before the game core sees them: start button, reset button and 7 mole switches.
- Per channel: 2-FF synchroniser, tick-based debounce, then one-cycle rise/fall/toggle pulses.
- The game core consumes the clean levels and pulses, so it no longer does its own ad-hoc edge detection on raw pins.

Parameters:
- N_CH, 9, number of input channels (bit 0 start, bit 1 reset, bits 8:2 switches[6:0]).
- CLK_HZ, 50_000_000, clk frequency.
- TICK_HZ, 1000, debounce sampling rate; TICK_DIV = CLK_HZ/TICK_HZ (integer, >=2).
- STABLE_TICKS, 10, consecutive ticks a new level must persist before acceptance (>=1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- raw_in  input  N_CH  unsynchronised button/switch pins.
- clean  output  N_CH  debounced levels.
- rise  output  N_CH  one-cycle pulse, 0->1 on clean.
- fall  output  N_CH  one-cycle pulse, 1->0 on clean.
- toggle  output  N_CH  rise | fall.
- armed  output  1  high once the power-up settle period is complete.
- tick  output  1  one-cycle sampling strobe (debug/observability).

Behaviour:
- Reset (rst_n=0, async): sync FFs, clean, rise, fall, toggle, armed, tick = 0; prescaler = 0; all per-channel counters = 0.
- Synchroniser: s1 <= raw_in; s2 <= s1. s2 is the only value used downstream. raw to s2 latency is 2 clk.
- Prescaler:
  - Counts 0..TICK_DIV-1 then wraps.
  - tick = 1 for exactly the one cycle in which the prescaler equals TICK_DIV-1. Period is TICK_DIV clk.
  - Free-running; unaffected by input activity.
- Settle phase (armed=0):
  - On each tick, clean <= s2 with no pulses and counters held at 0.
  - A settle counter increments per tick; armed <= 1 on the tick where it reaches STABLE_TICKS.
  - Power-up-pressed buttons therefore never produce spurious rise pulses.
- Per channel, once armed (implicit 2-state FSM: IDLE when cnt=0, PENDING when cnt>0):
  - Evaluated on tick cycles only. Between ticks, state holds.
  - If s2 == clean: cnt <= 0 (glitch rejected, return to IDLE).
  - If s2 != clean and cnt < STABLE_TICKS-1: cnt <= cnt+1.
  - If s2 != clean and cnt == STABLE_TICKS-1: clean <= s2, cnt <= 0. In the same registered update, rise or fall <= 1 per direction, and toggle <= 1.
  - Counter width is clog2(STABLE_TICKS). It must never wrap.
- Pulses:
  - Registered. High in the same cycle the new clean value first appears; cleared on the next clk.
  - Never asserted while armed=0.
- Latency:
  - A raw change that stays stable is accepted on the STABLE_TICKS-th tick whose sample sees it.
  - Worst case is 2 + STABLE_TICKS*TICK_DIV clk; best case is 2 + (STABLE_TICKS-1)*TICK_DIV + 1.
- Concurrency:
  - Channels are fully independent. Any number may pulse in the same cycle.
  - Bounce shorter than one tick period may be missed entirely. This is intended.
- STABLE_TICKS=1: acceptance on the first tick that sees the difference.
- Reset mid-operation: all state clears immediately; the settle phase re-runs; no pulse is emitted on exit from reset.

Test Plan (bench params CLK_HZ=1000, TICK_HZ=100 -> TICK_DIV=10, STABLE_TICKS=3):
- Power-up with raw_in=9'h001 held -> armed rises at the 3rd tick (cycle 30 after reset release); clean=9'h001; rise stays 0 throughout.
- Armed, raw_in[2] 0->1 held -> clean[2] rises between 22 and 33 clk later, together with a single-cycle rise[2]=1 and toggle[2]=1; fall=0.
- Armed, raw_in[3] high for 15 clk then low -> sampled by at most 2 ticks; clean[3] stays 0; no pulses.
- Armed, raw_in toggles 1/0 every 12 clk for 200 clk -> counter resets repeatedly; no pulses; clean unchanged.
- raw_in[0] and raw_in[8] change 0->1 in the same cycle and are held -> rise[0] and rise[8] assert in the same cycle.
- rst_n pulsed low for 3 clk while channel 4 is PENDING (cnt=2) -> all outputs 0 within the reset; armed=0; settle re-runs; no fall or rise on channel 4 after release.
